// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the serial-in/serial-out delay line.
package shift_register_pkg;

  localparam int SHIFT_REGISTER_DEPTH_DEFAULT = 4;

  // Stage-vector width: never narrower than one bit, even for a bad DEPTH.
  function automatic int stage_width(input int depth);
    return (depth < 1) ? 1 : depth;
  endfunction

endpackage

// File: rtl/shift_register_if.sv
// Data bus of the shift register. When SHIFT_REGISTER_PARALLEL_OUT_EN is defined,
// the bus also carries a parallel view of every stage.
interface shift_register_if #(
  parameter int DEPTH = shift_register_pkg::SHIFT_REGISTER_DEPTH_DEFAULT
);
  logic si;
  logic so;
`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
  logic [DEPTH-1:0] pout;
`endif

  modport master (
    output si,
    input  so
`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
    , input pout
`endif
  );

  modport slave (
    input  si,
    output so
`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
    , output pout
`endif
  );
endinterface

// File: rtl/shift_register_stage.sv
// One stage of the delay line: a D flip-flop with synchronous active-high reset.
module shift_register_stage (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/shift_register.sv
// SISO shift register built from a chain of DEPTH stages; so is stage[DEPTH-1].
// Optional parallel output of all stages is enabled by SHIFT_REGISTER_PARALLEL_OUT_EN.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int DEPTH = SHIFT_REGISTER_DEPTH_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  shift_register_if.slave  bus
);

  localparam int WIDTH = stage_width(DEPTH);

  logic [WIDTH-1:0] stage;

  // stage[0] samples si; each later stage samples its predecessor.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      shift_register_stage u_stage (
        .clk   (clk),
        .reset (reset),
        .d     (bus.si),
        .q     (stage[i])
      );
    end else begin : g_next
      shift_register_stage u_stage (
        .clk   (clk),
        .reset (reset),
        .d     (stage[i-1]),
        .q     (stage[i])
      );
    end
  end

  assign bus.so = stage[WIDTH-1];

`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
  assign bus.pout = stage;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Randomized and directed bench for shift_register at DEPTH=4 and DEPTH=1,
// checked against a history-of-inputs delay model.
module tb_shift_register;

  logic clk;
  logic reset;

  int tests_run = 0;
  int failures  = 0;

  // Inputs accepted since the last reset, oldest first.
  bit hist4[$];
  bit hist1[$];

  shift_register_if #(.DEPTH(4)) bus4 ();
  shift_register_if #(.DEPTH(1)) bus1 ();

  shift_register #(.DEPTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  shift_register #(.DEPTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // so after n accepted edges is the input from DEPTH edges earlier, else 0.
  function automatic logic exp_so4();
    if (hist4.size() >= 4) return hist4[hist4.size() - 4];
    return 1'b0;
  endfunction

  function automatic logic exp_so1();
    if (hist1.size() >= 1) return hist1[hist1.size() - 1];
    return 1'b0;
  endfunction

  // Stage i holds the input accepted i edges before the most recent one.
  function automatic logic [3:0] exp_pout4();
    logic [3:0] v;
    v = 4'b0;
    for (int i = 0; i < 4; i++)
      if (hist4.size() > i) v[i] = hist4[hist4.size() - 1 - i];
    return v;
  endfunction

  // Drive one edge's worth of inputs, update the model, sample #1 after the edge.
  task automatic tick(input logic s4, input logic s1, input logic r);
    @(negedge clk);
    bus4.si = s4;
    bus1.si = s1;
    reset   = r;
    @(posedge clk);
    if (r) begin
      hist4.delete();
      hist1.delete();
    end else begin
      hist4.push_back(s4);
      hist1.push_back(s1);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tests_run++;
    if (bus4.so !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_so4: got %b expected %b", bus4.so, 1'b0);
    end
    tests_run++;
    if (bus1.so !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_so1: got %b expected %b", bus1.so, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus4.so !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold_%0d: got %b expected %b", i, bus4.so, 1'b0);
      end
    end
  endtask

  task automatic test_single_pulse();
    int ones;
    ones = 0;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick((i == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus4.so !== ((i == 3) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("[TB] FAIL pulse_edge_%0d: got %b expected %b", i + 1, bus4.so,
                 (i == 3) ? 1'b1 : 1'b0);
      end
      if (bus4.so === 1'b1) ones++;
    end
    tests_run++;
    if (ones != 1) begin
      failures++;
      $display("[TB] FAIL pulse_width: got %0d cycles high expected 1", ones);
    end
  endtask

  task automatic test_pattern();
    logic [7:0] pat;
    logic [7:0] want;
    pat  = 8'b00001101;
    want = 8'b01101000;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(pat[i], 1'b0, 1'b0);
      tests_run++;
      if (bus4.so !== want[i]) begin
        failures++;
        $display("[TB] FAIL pattern_edge_%0d: got %b expected %b", i + 1, bus4.so, want[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tests_run++;
    if (bus4.so !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_reset: got %b expected %b", bus4.so, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      tests_run++;
      if (bus4.so !== ((i == 3) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("[TB] FAIL prio_edge_%0d: got %b expected %b", i + 1, bus4.so,
                 (i == 3) ? 1'b1 : 1'b0);
      end
    end
  endtask

  task automatic test_depth1();
    logic [3:0] pat;
    pat = 4'b0110;
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, pat[i], 1'b0);
      tests_run++;
      if (bus1.so !== pat[i]) begin
        failures++;
        $display("[TB] FAIL depth1_edge_%0d: got %b expected %b", i + 1, bus1.so, pat[i]);
      end
    end
  endtask

  // A reset pulse entirely between rising edges must be ignored.
  task automatic test_glitch_reset();
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus4.si = 1'b0;
    bus1.si = 1'b0;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk);
    hist4.push_back(1'b0);
    hist1.push_back(1'b0);
    #1;
    tests_run++;
    if (bus4.so !== 1'b1) begin
      failures++;
      $display("[TB] FAIL glitch_so4: got %b expected %b", bus4.so, 1'b1);
    end
    tests_run++;
    if (bus1.so !== 1'b0) begin
      failures++;
      $display("[TB] FAIL glitch_so1: got %b expected %b", bus1.so, 1'b0);
    end
  endtask

  task automatic test_random();
    logic s4, s1, r, e4, e1;
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      s4 = 1'($urandom);
      s1 = 1'($urandom);
      r  = ($urandom_range(15) == 0);
      tick(s4, s1, r);
      e4 = exp_so4();
      e1 = exp_so1();
      tests_run++;
      if (bus4.so !== e4) begin
        failures++;
        $display("[TB] FAIL random_so4_%0d: got %b expected %b", i, bus4.so, e4);
      end
      tests_run++;
      if (bus1.so !== e1) begin
        failures++;
        $display("[TB] FAIL random_so1_%0d: got %b expected %b", i, bus1.so, e1);
      end
`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
      tests_run++;
      if (bus4.pout !== exp_pout4()) begin
        failures++;
        $display("[TB] FAIL random_pout_%0d: got %b expected %b", i, bus4.pout, exp_pout4());
      end
`endif
    end
  endtask

`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
  task automatic test_parallel_out();
    logic [3:0] pat;
    pat = 4'b0001;
    tick(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (bus4.pout !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL pout_reset: got %b expected %b", bus4.pout, 4'b0000);
    end
    for (int i = 0; i < 4; i++) tick(pat[i], 1'b0, 1'b0);
    tests_run++;
    if (bus4.pout !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL pout_loaded: got %b expected %b", bus4.pout, 4'b1000);
    end
    tests_run++;
    if (bus4.so !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pout_so: got %b expected %b", bus4.so, 1'b1);
    end
    tick(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (bus4.pout !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL pout_drain: got %b expected %b", bus4.pout, 4'b0000);
    end
  endtask
`endif

  initial begin
    reset   = 1'b0;
    bus4.si = 1'b0;
    bus1.si = 1'b0;
    test_reset();
    test_single_pulse();
    test_pattern();
    test_reset_priority();
    test_depth1();
    test_glitch_reset();
    test_random();
`ifdef SHIFT_REGISTER_PARALLEL_OUT_EN
    test_parallel_out();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
